// File: rtl/dec_opnd_issue_pkg.sv
// Shared types and helpers for the decode/operand-issue stage.
package dec_opnd_issue_pkg;

    localparam int unsigned REG_N     = 16;
    localparam int unsigned REG_IDX_W = $clog2(REG_N);
    localparam int unsigned XLEN      = 32;
    localparam int unsigned OP_W      = 8;

    typedef logic [XLEN-1:0]      reg_t;
    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [OP_W-1:0]      opcode_t;

    // Highest register index aliases the instruction pointer.
    localparam reg_idx_t RIP    = reg_idx_t'(REG_N - 1);
    localparam opcode_t  OP_NOP = '0;

    typedef struct packed {
        opcode_t  op;
        reg_idx_t d;
        reg_idx_t s;
        reg_idx_t t;
        reg_t     pc;
    } miinst_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } skid_state_t;

    function automatic miinst_t nop(input reg_t pc);
        miinst_t i;
        i    = '0;
        i.op = OP_NOP;
        i.pc = pc;
        return i;
    endfunction

    // Source slot k of an instruction: 0 = d, 1 = s, 2 = t.
    function automatic reg_idx_t src_idx(input miinst_t i, input int k);
        reg_idx_t r;
        case (k)
            0:       r = i.d;
            1:       r = i.s;
            default: r = i.t;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dec_opnd_issue_if.sv
// Queue-head and execute-side handshakes of the operand-issue stage.
interface dec_opnd_issue_if import dec_opnd_issue_pkg::*; #(
    parameter int unsigned NSRC = 3
) ();

    logic              in_valid;
    logic              in_ready;
    miinst_t           in_inst;
    logic              out_valid;
    logic              out_ready;
    miinst_t           out_inst;
    reg_t [NSRC-1:0]   out_opnd;

    modport master (
        output in_valid, in_inst, out_ready,
        input  in_ready, out_valid, out_inst, out_opnd
    );

    modport slave (
        input  in_valid, in_inst, out_ready,
        output in_ready, out_valid, out_inst, out_opnd
    );

endinterface

// File: rtl/dec_opnd_issue_opnd_resolve.sv
// Combinational resolver for one source operand: RIP, forwarding, or GPR.
module opnd_resolve import dec_opnd_issue_pkg::*; #(
    parameter int unsigned FWD_N = 3
) (
    input  reg_idx_t              src,
    input  reg_t                  pc,
    input  reg_t     [REG_N-1:0]  gpr,
    input  logic     [FWD_N-1:0]  fwd_vld,
    input  reg_idx_t [FWD_N-1:0]  fwd_rd,
    input  logic     [FWD_N-1:0]  fwd_rdy,
    input  reg_t     [FWD_N-1:0]  fwd_val,
    output reg_t                  value_c,
    output logic                  unres_c
);

    logic found;

    // Youngest (lowest-index) matching producer wins, ready or not.
    always_comb begin
        value_c = gpr[src];
        unres_c = 1'b0;
        found   = 1'b0;
        if (src == RIP) begin
            value_c = reg_t'(pc + reg_t'(1));
        end else begin
            for (int unsigned j = 0; j < FWD_N; j++) begin
                if (!found && fwd_vld[j] && (fwd_rd[j] == src)) begin
                    found   = 1'b1;
                    value_c = fwd_val[j];
                    unres_c = ~fwd_rdy[j];
                end
            end
        end
    end

endmodule

// File: rtl/dec_opnd_issue.sv
// Decode/operand-issue stage: resolves sources, stalls on hazards and
// buffers accepted instructions in a 2-entry skid buffer toward execute.
module dec_opnd_issue import dec_opnd_issue_pkg::*; #(
    parameter int unsigned NSRC  = 3,
    parameter int unsigned FWD_N = 3,
    parameter int unsigned CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    dec_opnd_issue_if.slave       bus,
    input  reg_t     [REG_N-1:0]  gpr,
    input  logic     [FWD_N-1:0]  fwd_vld,
    input  reg_idx_t [FWD_N-1:0]  fwd_rd,
    input  logic     [FWD_N-1:0]  fwd_rdy,
    input  reg_t     [FWD_N-1:0]  fwd_val,
    input  logic                  flush,
    output logic                  hazard,
    output logic     [CNT_W-1:0]  stall_cnt
);

    skid_state_t      state;
    logic             valid_q;
    miinst_t          main_inst;
    miinst_t          skid_inst;
    reg_t [NSRC-1:0]  main_opnd;
    reg_t [NSRC-1:0]  skid_opnd;
    logic [CNT_W-1:0] stall_q;

    reg_t [NSRC-1:0]  opnd_c;
    logic [NSRC-1:0]  unres_c;
    logic             accept;

    for (genvar k = 0; k < NSRC; k++) begin : g_src
        opnd_resolve #(.FWD_N(FWD_N)) u_res (
            .src     (src_idx(bus.in_inst, k)),
            .pc      (bus.in_inst.pc),
            .gpr     (gpr),
            .fwd_vld (fwd_vld),
            .fwd_rd  (fwd_rd),
            .fwd_rdy (fwd_rdy),
            .fwd_val (fwd_val),
            .value_c (opnd_c[k]),
            .unres_c (unres_c[k])
        );
    end

    assign hazard       = bus.in_valid & (|unres_c);
    assign bus.in_ready = (state != SKID) & ~hazard & ~flush;
    assign accept       = bus.in_valid & bus.in_ready;

    assign bus.out_valid = valid_q;
    assign bus.out_inst  = main_inst;
    assign bus.out_opnd  = main_opnd;
    assign stall_cnt     = stall_q;

    // Skid buffer FSM, entry registers and saturating stall counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= EMPTY;
            valid_q   <= 1'b0;
            main_inst <= nop('0);
            skid_inst <= nop('0);
            main_opnd <= '0;
            skid_opnd <= '0;
            stall_q   <= '0;
        end else begin
            if (hazard && !flush && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (flush) begin
                state     <= EMPTY;
                valid_q   <= 1'b0;
                main_inst <= nop('0);
                skid_inst <= nop('0);
                main_opnd <= '0;
                skid_opnd <= '0;
            end else begin
                case (state)
                    EMPTY: begin
                        if (accept) begin
                            state     <= FULL;
                            valid_q   <= 1'b1;
                            main_inst <= bus.in_inst;
                            main_opnd <= opnd_c;
                        end
                    end
                    FULL: begin
                        if (accept && bus.out_ready) begin
                            main_inst <= bus.in_inst;
                            main_opnd <= opnd_c;
                        end else if (accept) begin
                            state     <= SKID;
                            skid_inst <= bus.in_inst;
                            skid_opnd <= opnd_c;
                        end else if (bus.out_ready) begin
                            state     <= EMPTY;
                            valid_q   <= 1'b0;
                            main_inst <= nop('0);
                            main_opnd <= '0;
                        end
                    end
                    SKID: begin
                        if (bus.out_ready) begin
                            state     <= FULL;
                            main_inst <= skid_inst;
                            main_opnd <= skid_opnd;
                            skid_inst <= nop('0);
                            skid_opnd <= '0;
                        end
                    end
                    default: begin
                        state   <= EMPTY;
                        valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dec_opnd_issue.sv
// Directed self-checking bench for dec_opnd_issue.
module tb_dec_opnd_issue;
    import dec_opnd_issue_pkg::*;

    logic                 clk = 1'b0;
    logic                 rstn;
    reg_t     [REG_N-1:0] gpr;
    logic     [2:0]       fwd_vld;
    reg_idx_t [2:0]       fwd_rd;
    logic     [2:0]       fwd_rdy;
    reg_t     [2:0]       fwd_val;
    logic                 flush;
    logic                 hazard1, hazard2;
    logic     [31:0]      cnt1;
    logic     [3:0]       cnt2;

    int n_run  = 0;
    int n_fail = 0;

    miinst_t ia, ib, ic;

    dec_opnd_issue_if #(.NSRC(3)) bus1 ();
    dec_opnd_issue_if #(.NSRC(3)) bus2 ();

    dec_opnd_issue #(.NSRC(3), .FWD_N(3), .CNT_W(32)) dut (
        .clk(clk), .rstn(rstn), .bus(bus1), .gpr(gpr),
        .fwd_vld(fwd_vld), .fwd_rd(fwd_rd), .fwd_rdy(fwd_rdy), .fwd_val(fwd_val),
        .flush(flush), .hazard(hazard1), .stall_cnt(cnt1)
    );

    dec_opnd_issue #(.NSRC(3), .FWD_N(3), .CNT_W(4)) dut4 (
        .clk(clk), .rstn(rstn), .bus(bus2), .gpr(gpr),
        .fwd_vld(fwd_vld), .fwd_rd(fwd_rd), .fwd_rdy(fwd_rdy), .fwd_val(fwd_val),
        .flush(flush), .hazard(hazard2), .stall_cnt(cnt2)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic miinst_t mk(input opcode_t op, input reg_idx_t d, input reg_idx_t s,
                                   input reg_idx_t t, input reg_t pc);
        miinst_t i;
        i.op = op; i.d = d; i.s = s; i.t = t; i.pc = pc;
        return i;
    endfunction

    initial begin
        rstn = 1'b0; flush = 1'b0;
        fwd_vld = '0; fwd_rd = '0; fwd_rdy = '0; fwd_val = '0;
        for (int i = 0; i < 16; i++) gpr[i] = 32'h1000 + 32'(i);
        gpr[3] = 32'h55;
        bus1.in_valid = 1'b0; bus1.in_inst = nop('0); bus1.out_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.in_inst = nop('0); bus2.out_ready = 1'b1;
        repeat (2) @(negedge clk);

        // reset state
        chk("rst_valid", 64'(bus1.out_valid), 64'(0));
        chk("rst_inst",  64'(bus1.out_inst), 64'(nop('0)));
        chk("rst_opnd",  64'(bus1.out_opnd), 64'(0));
        chk("rst_cnt",   64'(cnt1), 64'(0));
        chk("rst_cnt4",  64'(cnt2), 64'(0));
        rstn = 1'b1;

        // plain GPR read
        ia = mk(8'd1, 4'd1, 4'd3, 4'd2, 32'h10);
        bus1.in_inst = ia; bus1.in_valid = 1'b1; bus1.out_ready = 1'b1;
        #1 chk("t1_in_ready", 64'(bus1.in_ready), 64'(1));
        tick();
        chk("t1_valid", 64'(bus1.out_valid), 64'(1));
        chk("t1_inst",  64'(bus1.out_inst), 64'(ia));
        chk("t1_op0",   64'(bus1.out_opnd[0]), 64'(32'h1001));
        chk("t1_op1",   64'(bus1.out_opnd[1]), 64'(32'h55));
        chk("t1_op2",   64'(bus1.out_opnd[2]), 64'(32'h1002));
        chk("t1_cnt",   64'(cnt1), 64'(0));

        // RIP source ignores a non-ready producer aimed at the RIP index
        bus1.in_inst = mk(8'd2, RIP, 4'd1, 4'd2, 32'h100);
        fwd_vld[1] = 1'b1; fwd_rd[1] = RIP; fwd_rdy[1] = 1'b0; fwd_val[1] = 32'hDEAD;
        #1 chk("t2_hazard", 64'(hazard1), 64'(0));
        tick();
        chk("t2_op0", 64'(bus1.out_opnd[0]), 64'(32'h101));
        chk("t2_op1", 64'(bus1.out_opnd[1]), 64'(32'h1001));

        // youngest producer wins
        fwd_vld = 3'b101; fwd_rd[0] = 4'd5; fwd_rd[2] = 4'd5;
        fwd_rdy = 3'b101; fwd_val[0] = 32'hA; fwd_val[2] = 32'hC;
        bus1.in_inst = mk(8'd3, 4'd1, 4'd5, 4'd2, 32'h20);
        fwd_rdy[0] = 1'b0;
        #1 chk("t3_lo_notrdy_hz", 64'(hazard1), 64'(1));
        chk("t3_lo_notrdy_rdy", 64'(bus1.in_ready), 64'(0));
        fwd_rdy[0] = 1'b1;
        #1 chk("t3_hazard", 64'(hazard1), 64'(0));
        tick();
        chk("t3_op1", 64'(bus1.out_opnd[1]), 64'(32'hA));

        // 3-cycle stall on forwarding slot 1
        fwd_vld = 3'b010; fwd_rd[1] = 4'd4; fwd_rdy = 3'b000; fwd_val[1] = 32'h44;
        ib = mk(8'd4, 4'd1, 4'd4, 4'd2, 32'h30);
        bus1.in_inst = ib;
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("t4_stall%0d", i), 64'(bus1.in_ready), 64'(0));
            tick();
        end
        chk("t4_cnt3",   64'(cnt1), 64'(3));
        chk("t4_drain",  64'(bus1.out_valid), 64'(0));
        fwd_rdy[1] = 1'b1;
        #1 chk("t4_rdy", 64'(bus1.in_ready), 64'(1));
        tick();
        chk("t4_inst", 64'(bus1.out_inst), 64'(ib));
        chk("t4_op1",  64'(bus1.out_opnd[1]), 64'(32'h44));
        chk("t4_cnt",  64'(cnt1), 64'(3));
        fwd_vld = '0; fwd_rdy = '0;
        bus1.in_valid = 1'b0;
        tick();
        chk("t5_empty", 64'(bus1.out_valid), 64'(0));

        // back-pressure fills the skid entry, then both drain in order
        ia = mk(8'd5, 4'd1, 4'd3, 4'd2, 32'h200);
        ib = mk(8'd6, 4'd1, 4'd6, 4'd2, 32'h201);
        bus1.out_ready = 1'b0; bus1.in_valid = 1'b1; bus1.in_inst = ia;
        tick();
        bus1.in_inst = ib;
        tick();
        #1 chk("t5_skid_rdy", 64'(bus1.in_ready), 64'(0));
        bus1.in_valid = 1'b0;
        chk("t5_main_a", 64'(bus1.out_inst), 64'(ia));
        chk("t5_op1_a",  64'(bus1.out_opnd[1]), 64'(32'h55));
        bus1.out_ready = 1'b1;
        tick();
        chk("t5_main_b", 64'(bus1.out_inst), 64'(ib));
        chk("t5_op1_b",  64'(bus1.out_opnd[1]), 64'(32'h1006));
        chk("t5_vld_b",  64'(bus1.out_valid), 64'(1));
        tick();
        chk("t5_done_v", 64'(bus1.out_valid), 64'(0));
        chk("t5_done_i", 64'(bus1.out_inst), 64'(nop('0)));
        chk("t5_done_o", 64'(bus1.out_opnd[1]), 64'(0));

        // flush in SKID; head is held, then accepted afterwards
        bus1.out_ready = 1'b0; bus1.in_valid = 1'b1;
        bus1.in_inst = mk(8'd7, 4'd1, 4'd2, 4'd3, 32'h300);
        tick();
        bus1.in_inst = mk(8'd8, 4'd1, 4'd2, 4'd3, 32'h301);
        tick();
        ic = mk(8'd9, 4'd7, 4'd8, 4'd9, 32'h302);
        bus1.in_inst = ic; flush = 1'b1;
        #1 chk("t6_flush_rdy", 64'(bus1.in_ready), 64'(0));
        tick();
        flush = 1'b0;
        chk("t6_flush_v", 64'(bus1.out_valid), 64'(0));
        chk("t6_flush_i", 64'(bus1.out_inst), 64'(nop('0)));
        #1 chk("t6_head_rdy", 64'(bus1.in_ready), 64'(1));
        tick();
        chk("t6_head_i", 64'(bus1.out_inst), 64'(ic));
        chk("t6_head_o", 64'(bus1.out_opnd), 64'({32'h1009, 32'h1008, 32'h1007}));
        bus1.in_valid = 1'b0; bus1.out_ready = 1'b1;
        tick();

        // 4-bit counter saturates at 15
        bus2.in_valid = 1'b1; bus2.in_inst = mk(8'd1, 4'd1, 4'd7, 4'd2, 32'h40);
        fwd_vld = 3'b001; fwd_rd[0] = 4'd7; fwd_rdy = 3'b000;
        #1 chk("t7_hazard", 64'(hazard2), 64'(1));
        chk("t7_gate", 64'(hazard1), 64'(0));
        repeat (14) tick();
        chk("t7_cnt14", 64'(cnt2), 64'(14));
        repeat (6) tick();
        chk("t7_cnt15", 64'(cnt2), 64'(15));
        chk("t7_cnt1",  64'(cnt1), 64'(3));
        bus2.in_valid = 1'b0; fwd_vld = '0;

        // async reset mid-operation drops the entry
        bus1.out_ready = 1'b0; bus1.in_valid = 1'b1; bus1.in_inst = ia;
        tick();
        chk("t8_pre", 64'(bus1.out_valid), 64'(1));
        bus1.in_valid = 1'b0;
        rstn = 1'b0;
        #1 chk("t8_rst_v", 64'(bus1.out_valid), 64'(0));
        chk("t8_rst_i", 64'(bus1.out_inst), 64'(nop('0)));
        chk("t8_rst_c", 64'(cnt1), 64'(0));
        rstn = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
